// File: rtl/mem_refill_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// refill_pkg
// Shared types and helpers for the memory refill arbiter.
//   RefillStates : arbiter FSM states
//   RefillSrc    : requester identity (instruction / data cache)
//   block_offset_width() : byte-offset bits inside one refill block
//   word_byte_shift()    : log2 of bytes per memory word
// -----------------------------------------------------------------------------
package refill_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REFILL_I = 3'd1,
    REFILL_D = 3'd2,
    DONE_I   = 3'd3,
    DONE_D   = 3'd4
  } RefillStates;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } RefillSrc;

  function automatic int block_offset_width(input int block_words, input int data_width);
    return $clog2(block_words * data_width / 8);
  endfunction

  function automatic int word_byte_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/mem_refill_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_refill_arbiter_if
// Bundles the cache miss requests, the memory read port, the refill write
// path and the stall outputs of the refill arbiter.
//   slave  modport : the arbiter (takes i* signals, drives o* signals)
//   master modport : the surrounding caches/memory/pipeline
// -----------------------------------------------------------------------------
interface mem_refill_arbiter_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4
);
  logic                           iIcMissReq;
  logic [ADDR_WIDTH-1:0]          iIcMissAddr;
  logic                           iDcMissReq;
  logic [ADDR_WIDTH-1:0]          iDcMissAddr;
  logic                           oMemReq;
  logic [ADDR_WIDTH-1:0]          oMemAddr;
  logic                           iMemAck;
  logic [DATA_WIDTH-1:0]          iMemRdata;
  logic [DATA_WIDTH-1:0]          oRefillData;
  logic [$clog2(BLOCK_WORDS)-1:0] oRefillWordIdx;
  logic                           oIcRefillWe;
  logic                           oDcRefillWe;
  logic                           oIcRefillDone;
  logic                           oDcRefillDone;
  logic                           oStallF;
  logic                           oStallPipe;

  modport slave (
    input  iIcMissReq, iIcMissAddr, iDcMissReq, iDcMissAddr, iMemAck, iMemRdata,
    output oMemReq, oMemAddr, oRefillData, oRefillWordIdx,
           oIcRefillWe, oDcRefillWe, oIcRefillDone, oDcRefillDone, oStallF, oStallPipe
  );

  modport master (
    output iIcMissReq, iIcMissAddr, iDcMissReq, iDcMissAddr, iMemAck, iMemRdata,
    input  oMemReq, oMemAddr, oRefillData, oRefillWordIdx,
           oIcRefillWe, oDcRefillWe, oIcRefillDone, oDcRefillDone, oStallF, oStallPipe
  );
endinterface

// File: rtl/mem_refill_arbiter_beat_counter.sv
// -----------------------------------------------------------------------------
// refill_beat_counter
// Latches the block-aligned base of the granted miss, counts beats and forms
// the word address of the current beat.
//   iClk, iRst   : clock, synchronous active-high reset
//   i_load       : capture i_miss_addr as the new block, restart at beat 0
//   i_miss_addr  : byte address of the granted miss
//   i_beat_ack   : current beat accepted by memory, advance
//   o_addr       : base + beat * bytes-per-word
//   o_beat       : beat index within the block
//   o_last       : current beat is the final one of the block
// -----------------------------------------------------------------------------
module refill_beat_counter
  import refill_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                           iClk,
  input  logic                           iRst,
  input  logic                           i_load,
  input  logic [ADDR_WIDTH-1:0]          i_miss_addr,
  input  logic                           i_beat_ack,
  output logic [ADDR_WIDTH-1:0]          o_addr,
  output logic [$clog2(BLOCK_WORDS)-1:0] o_beat,
  output logic                           o_last
);
  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W = block_offset_width(BLOCK_WORDS, DATA_WIDTH);
  localparam int SHIFT = word_byte_shift(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] BASE_MASK =
    ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));

  logic [ADDR_WIDTH-1:0] r_base;
  logic [IDX_W-1:0]      r_beat;
  logic [ADDR_WIDTH-1:0] w_offset;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_base <= '0;
      r_beat <= '0;
    end else if (i_load) begin
      r_base <= i_miss_addr & BASE_MASK;
      r_beat <= '0;
    end else if (i_beat_ack) begin
      // wraps to 0 after the last beat; the FSM leaves REFILL at that point
      r_beat <= r_beat + 1'b1;
    end
  end

  // offset only occupies the cleared low bits, so OR never carries out of the block
  assign w_offset = ADDR_WIDTH'(r_beat) << SHIFT;
  assign o_addr   = r_base | w_offset;
  assign o_beat   = r_beat;
  assign o_last   = (r_beat == IDX_W'(BLOCK_WORDS - 1));

endmodule

// File: rtl/mem_refill_arbiter.sv
// -----------------------------------------------------------------------------
// mem_refill_arbiter
// Shares one memory read port between I-cache and D-cache block refills and
// raises the fetch / whole-pipeline stall requests while refills are pending.
//   iClk, iRst : clock, synchronous active-high reset
//   bus        : mem_refill_arbiter_if.slave (miss requests, memory port,
//                refill write path, done pulses, stalls)
// Build option: ARB_ROUND_ROBIN_EN -- simultaneous I/D requests alternate
// grants instead of always favouring D.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no refill; arbitrate pending misses
// REFILL_I | streaming I-cache block, one beat per memory ack
// REFILL_D | streaming D-cache block, one beat per memory ack
// DONE_I   | I block complete, pulse oIcRefillDone
// DONE_D   | D block complete, pulse oDcRefillDone
// -----------------------------------------------------------------------------
module mem_refill_arbiter
  import refill_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4
) (
  input logic                 iClk,
  input logic                 iRst,
  mem_refill_arbiter_if.slave bus
);
  RefillStates           r_state, w_next;
  RefillSrc              w_grant_src;
  logic                  w_grant_valid;
  logic                  w_both_req;
  logic                  w_refill_active;
  logic                  w_beat_ack;
  logic                  w_load;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_load_addr;

`ifdef ARB_ROUND_ROBIN_EN
  RefillSrc r_last_grant;
`endif

  assign w_both_req = bus.iIcMissReq & bus.iDcMissReq;

  always_comb begin
    w_grant_valid = bus.iIcMissReq | bus.iDcMissReq;
    w_grant_src   = bus.iDcMissReq ? SRC_D : SRC_I;
`ifdef ARB_ROUND_ROBIN_EN
    if (w_both_req && (r_last_grant == SRC_D)) w_grant_src = SRC_I;
`endif
  end

  always_ff @(posedge iClk) begin
    if (iRst) r_state <= IDLE;
    else      r_state <= w_next;
  end

`ifdef ARB_ROUND_ROBIN_EN
  // only contended grants update the history; a lone request is not a "turn"
  always_ff @(posedge iClk) begin
    if (iRst)                              r_last_grant <= SRC_I;
    else if ((r_state == IDLE) && w_both_req) r_last_grant <= w_grant_src;
  end
`endif

  always_comb begin
    w_next          = r_state;
    w_refill_active = 1'b0;
    w_load          = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_load = 1'b1;
          w_next = (w_grant_src == SRC_D) ? REFILL_D : REFILL_I;
        end
      end
      REFILL_I: begin
        w_refill_active = 1'b1;
        if (bus.iMemAck && w_last) w_next = DONE_I;
      end
      REFILL_D: begin
        w_refill_active = 1'b1;
        if (bus.iMemAck && w_last) w_next = DONE_D;
      end
      DONE_I, DONE_D: w_next = IDLE;
      default:        w_next = IDLE;
    endcase
  end

  // acks outside a refill are dropped here, so a stray ack never writes a line
  assign w_beat_ack  = w_refill_active & bus.iMemAck;
  assign w_load_addr = (w_grant_src == SRC_D) ? bus.iDcMissAddr : bus.iIcMissAddr;

  refill_beat_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BLOCK_WORDS(BLOCK_WORDS)
  ) u_beat_counter (
    .iClk       (iClk),
    .iRst       (iRst),
    .i_load     (w_load),
    .i_miss_addr(w_load_addr),
    .i_beat_ack (w_beat_ack),
    .o_addr     (bus.oMemAddr),
    .o_beat     (bus.oRefillWordIdx),
    .o_last     (w_last)
  );

  assign bus.oMemReq       = w_refill_active;
  assign bus.oRefillData   = bus.iMemRdata;
  assign bus.oIcRefillWe   = w_beat_ack & (r_state == REFILL_I);
  assign bus.oDcRefillWe   = w_beat_ack & (r_state == REFILL_D);
  assign bus.oIcRefillDone = (r_state == DONE_I);
  assign bus.oDcRefillDone = (r_state == DONE_D);
  assign bus.oStallF       = bus.iIcMissReq | (r_state == REFILL_I) | (r_state == DONE_I);
  assign bus.oStallPipe    = bus.iDcMissReq | (r_state == REFILL_D) | (r_state == DONE_D);

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_refill_arbiter
// Drives directed scenarios followed by randomized miss/ack traffic and
// compares every cycle against a transaction-level model of the arbiter.
// Honours ARB_ROUND_ROBIN_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_mem_refill_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int BLOCK_BYTES = BW * DW / 8;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_refill_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW)) bus ();

  mem_refill_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW)) dut (
    .iClk(clk),
    .iRst(rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  // model: owner 0=none 1=I 2=D, done marks the completion cycle
  int          m_owner = 0;
  int          m_beat  = 0;
  bit          m_done  = 1'b0;
  logic [31:0] m_base  = '0;
`ifdef ARB_ROUND_ROBIN_EN
  int          m_last  = 1;
`endif
  int          prev_done = 0;

  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = '0;
  logic        dc_req = 1'b0;
  logic [31:0] dc_addr = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic ic, input logic [31:0] ia,
                      input logic dc, input logic [31:0] da,
                      input logic ack, input logic [31:0] rd);
    bit busy, acc;
    int g;
    @(negedge clk);
    rst             = r;
    bus.iIcMissReq  = ic;
    bus.iIcMissAddr = ia;
    bus.iDcMissReq  = dc;
    bus.iDcMissAddr = da;
    bus.iMemAck     = ack;
    bus.iMemRdata   = rd;
    #1;
    busy = (m_owner != 0) && !m_done;
    acc  = busy && ack;
    chk("mem_req", bus.oMemReq, busy);
    if (busy) chk("mem_addr", bus.oMemAddr, m_base + 32'(m_beat * (DW / 8)));
    chk("ic_we", bus.oIcRefillWe, acc && (m_owner == 1));
    chk("dc_we", bus.oDcRefillWe, acc && (m_owner == 2));
    if (acc) begin
      chk("word_idx", bus.oRefillWordIdx, m_beat);
      chk("refill_data", bus.oRefillData, rd);
    end
    chk("ic_done", bus.oIcRefillDone, m_done && (m_owner == 1));
    chk("dc_done", bus.oDcRefillDone, m_done && (m_owner == 2));
    chk("stall_f", bus.oStallF, ic || (m_owner == 1));
    chk("stall_pipe", bus.oStallPipe, dc || (m_owner == 2));
    prev_done = m_done ? m_owner : 0;

    @(posedge clk);
    if (r) begin
      m_owner = 0; m_done = 1'b0; m_beat = 0; m_base = '0;
`ifdef ARB_ROUND_ROBIN_EN
      m_last = 1;
`endif
    end else if (m_done) begin
      m_owner = 0; m_done = 1'b0;
    end else if (m_owner == 0) begin
      g = 0;
      if (ic && dc) begin
`ifdef ARB_ROUND_ROBIN_EN
        g = (m_last == 2) ? 1 : 2;
        m_last = g;
`else
        g = 2;
`endif
      end else if (dc) g = 2;
      else if (ic)     g = 1;
      if (g != 0) begin
        m_owner = g;
        m_beat  = 0;
        m_base  = ((g == 2) ? da : ia) / BLOCK_BYTES * BLOCK_BYTES;
      end
    end else if (acc) begin
      if (m_beat == BW - 1) m_done = 1'b1;
      else                  m_beat++;
    end
  endtask

  // mode 0: ack every cycle, 1: two wait cycles per ack, 2: fully random
  task automatic run(input int n, input int mode);
    logic ack, r;
    for (int k = 0; k < n; k++) begin
      if (prev_done == 1) ic_req = 1'b0;
      if (prev_done == 2) dc_req = 1'b0;
      r   = 1'b0;
      ack = 1'b1;
      case (mode)
        0: ack = 1'b1;
        1: ack = (k % 3 == 2);
        default: begin
          r   = ($urandom_range(0, 499) == 0);
          ack = ($urandom_range(0, 2) != 0);
          if (!ic_req && $urandom_range(0, 5) == 0) begin
            ic_req = 1'b1; ic_addr = $urandom;
          end else if (ic_req && m_owner == 1 && !m_done && $urandom_range(0, 59) == 0) begin
            ic_req = 1'b0;
          end
          if (!dc_req && $urandom_range(0, 6) == 0) begin
            dc_req = 1'b1; dc_addr = $urandom;
          end else if (dc_req && m_owner == 2 && !m_done && $urandom_range(0, 59) == 0) begin
            dc_req = 1'b0;
          end
        end
      endcase
      step(r, ic_req, ic_addr, dc_req, dc_addr, ack, $urandom);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.iIcMissReq = 1'b0; bus.iIcMissAddr = '0;
    bus.iDcMissReq = 1'b0; bus.iDcMissAddr = '0;
    bus.iMemAck = 1'b0;    bus.iMemRdata = '0;

    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_addr", bus.oMemAddr, 32'h0);

    // lone I miss, zero-wait memory
    ic_req = 1'b1; ic_addr = 32'h0000_1234;
    run(8, 0);

    // simultaneous I and D misses
    ic_req = 1'b1; ic_addr = 32'h0000_0100;
    dc_req = 1'b1; dc_addr = 32'h0000_2008;
    run(16, 0);

    // two wait cycles before each ack
    ic_req = 1'b1; ic_addr = 32'h0000_0A5C;
    run(18, 1);

    // reset in the middle of a D refill; request held, restarts from beat 0
    dc_req = 1'b1; dc_addr = 32'h0000_4444;
    run(3, 0);
    step(1'b1, ic_req, ic_addr, dc_req, dc_addr, 1'b1, 32'h1111_2222);
    run(8, 0);

    // fetch redirected after beat 0: refill still completes, stray acks ignored
    ic_req = 1'b1; ic_addr = 32'h0000_0040;
    run(2, 0);
    ic_req = 1'b0;
    run(8, 0);

    // two back-to-back contended pairs
    ic_req = 1'b1; ic_addr = 32'h0000_0300;
    dc_req = 1'b1; dc_addr = 32'h0000_0700;
    run(12, 0);
    ic_req = 1'b1; ic_addr = 32'h0000_0310;
    dc_req = 1'b1; dc_addr = 32'h0000_0710;
    run(12, 0);

    run(3000, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
